mealy_sequence_detector: RTL and testbench

Serial bit-stream detector for the overlapping pattern 1-0-1-1, implemented as a Mealy state machine. One input bit is sampled per rising clock edge. `out` asserts combinationally while the machine holds the prefix "101" and the current input is 1. The current state is exported for debug and observation. The block sits directly on a single-bit serial data line in the `clk` domain.

---
 rtl/mealy_sequence_detector.sv | 54 +++++
 tb/tb_mealy_sequence_detector.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mealy_sequence_detector.sv
`default_nettype none
// ============================================================================
//  Module      : mealy_sequence_detector
//  Description : Mealy FSM that flags the overlapping serial pattern 1-0-1-1.
//                One bit is consumed per rising clock edge. The detect flag
//                is combinational: it is high while the machine holds "101"
//                and the current input bit is 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module mealy_sequence_detector (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic       out,
    output logic [2:0] state
);

    // Prefix-match states; codes 4..7 are unused and recover to S0.
    localparam logic [2:0] S0 = 3'd0;   // nothing matched
    localparam logic [2:0] S1 = 3'd1;   // "1"
    localparam logic [2:0] S2 = 3'd2;   // "10"
    localparam logic [2:0] S3 = 3'd3;   // "101"

    logic [2:0] state_q;
    logic [2:0] state_d;

    // Next-state logic: track the longest received suffix that is a prefix
    // of the pattern, so overlapping occurrences are detected.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = in ? S1 : S0;
            S1:      state_d = in ? S1 : S2;
            S2:      state_d = in ? S3 : S0;
            S3:      state_d = in ? S1 : S2;  // on a hit, trailing "1" is reused
            default: state_d = S0;            // illegal code recovers to idle
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Mealy output: 4th pattern bit present on the input while "101" is held.
    assign out   = rst & (state_q == S3) & in;
    assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mealy_sequence_detector.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
//  Module      : tb_mealy_sequence_detector
//  Description : Self-checking bench for mealy_sequence_detector. The
//                reference model keeps a history of the received bits and
//                derives the expected state as the longest history suffix
//                that is a proper prefix of 1011.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mealy_sequence_detector;

    logic       clk;
    logic       rst;
    logic       in;
    logic       out;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int det_cnt  = 0;

    // Reference model: last four accepted bits and how many are valid.
    logic [3:0] last4    = 4'd0;
    int         hist_len = 0;

    mealy_sequence_detector dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .out   (out),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Longest suffix of the history (up to 3 bits) equal to the pattern's prefix.
    function automatic logic [31:0] exp_state();
        logic [3:0] pat = 4'b1011;
        for (int k = 3; k >= 1; k--) begin
            logic [3:0] mask = 4'((1 << k) - 1);
            logic [3:0] pre  = pat >> (4 - k);
            if (hist_len >= k && ((last4 & mask) == pre)) return k;
        end
        return 0;
    endfunction

    function automatic void model_edge(input logic r, input logic b);
        if (!r) begin
            hist_len = 0;
            last4    = 4'd0;
        end else begin
            last4 = {last4[2:0], b};
            if (hist_len < 4) hist_len++;
        end
    endfunction

    // One cycle: drive at the falling edge, check out mid-cycle, check state after the rising edge.
    task automatic apply(input logic r, input logic b, input string tag);
        logic eo;
        @(negedge clk);
        rst = r;
        in  = b;
        #2;
        eo = r && (hist_len >= 3) && ({last4[2:0], b} == 4'b1011);
        check({tag, " out"}, 32'(out), 32'(eo));
        if (out) det_cnt++;
        @(posedge clk);
        model_edge(r, b);
        #1;
        check({tag, " state"}, 32'(state), exp_state());
    endtask

    task automatic apply_seq(input logic [15:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) apply(1'b1, bits[i], tag);
    endtask

    initial begin
        rst = 1'b0;
        in  = 1'b0;

        // Reset held for three edges with toggling input.
        apply(1'b0, 1'b1, "rst0");
        apply(1'b0, 1'b0, "rst1");
        apply(1'b0, 1'b1, "rst2");
        check("reset state", 32'(state), 32'd0);
        apply(1'b1, 1'b0, "idle0");

        // Basic detection 1011.
        det_cnt = 0;
        apply_seq(16'b1011, 4, "basic");
        check("basic detections", 32'(det_cnt), 32'd1);
        check("basic final state", 32'(state), 32'd1);

        // Overlap 1011011.
        apply(1'b0, 1'b0, "rstA");
        det_cnt = 0;
        apply_seq(16'b1011011, 7, "overlap");
        check("overlap detections", 32'(det_cnt), 32'd2);
        check("overlap final state", 32'(state), 32'd1);

        // 10110101100: hits on bits 4 and 9, ends in S0.
        apply(1'b0, 1'b0, "rstB");
        det_cnt = 0;
        apply_seq(16'b10110101100, 11, "seq11");
        check("seq11 detections", 32'(det_cnt), 32'd2);
        check("seq11 final state", 32'(state), 32'd0);

        // Glitches between edges while idle: only the edge value counts.
        apply(1'b0, 1'b0, "rstC");
        @(negedge clk);
        rst = 1'b1;
        in = 1'b1; #0.5; check("glitch out a", 32'(out), 32'd0);
        in = 1'b0; #0.5;
        in = 1'b1; #0.5; check("glitch out b", 32'(out), 32'd0);
        in = 1'b1; #0.5;
        in = 1'b0;
        @(posedge clk);
        model_edge(1'b1, 1'b0);
        #1;
        check("glitch state", 32'(state), 32'd0);

        // Glitch while in S3: out follows in, but the edge value decides.
        apply_seq(16'b101, 3, "pre3");
        @(negedge clk);
        in = 1'b1; #0.5; check("s3 glitch out hi", 32'(out), 32'd1);
        in = 1'b0; #1;   check("s3 glitch out lo", 32'(out), 32'd0);
        @(posedge clk);
        model_edge(1'b1, 1'b0);
        #1;
        check("s3 glitch state", 32'(state), 32'd2);

        // Mid-sequence reset discards the partial match.
        apply_seq(16'b101, 3, "mid");
        apply(1'b0, 1'b1, "midrst");
        det_cnt = 0;
        apply(1'b1, 1'b1, "midpost");
        check("midrst final state", 32'(state), 32'd1);
        check("midrst no detect", 32'(det_cnt), 32'd0);

        // Randomized stream with occasional resets.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 19) != 0), 1'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
